// File: rtl/apb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter_if
//
// Purpose:
//   Bundles the requester-side handshake and the APB master bus of
//   apb_master_arbiter into one interface.
//
// Signal summary (direction as seen by the arbiter):
//   req_valid  in   NUM_REQ     requester i has a transfer pending
//   req_write  in   NUM_REQ     1 = write, 0 = read, per requester
//   req_addr   in   NUM_REQ*32  requester i address in [32*i +: 32]
//   req_wdata  in   NUM_REQ*32  requester i write data in [32*i +: 32]
//   req_ready  out  NUM_REQ     one-hot accept strobe
//   rsp_valid  out  NUM_REQ     one-hot, one-cycle completion pulse
//   rsp_err    out  1           decode error or timeout, valid with rsp_valid
//   rsp_rdata  out  32          read data, valid with rsp_valid
//   PADDR      out  32          APB address
//   PWDATA     out  32          APB write data
//   PWRITE     out  1           APB direction
//   PSEL       out  16          APB one-hot slave select
//   PENABLE    out  1           APB access phase
//   PRDATA     in   32          APB read data
//   PREADY     in   1           APB slave ready
//
// Modports:
//   master : the arbiter (drives the APB bus and the requester responses)
//   slave  : the environment (requesters plus the APB slave fabric)
// ---------------------------------------------------------------------------
interface apb_master_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic                  rsp_err;
    logic [31:0]           rsp_rdata;

    logic [31:0]           PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic [15:0]           PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//
// Purpose:
//   Shares one APB master port between NUM_REQ requesters. Round-robin
//   arbitration, address decode onto the one-hot PSEL bus, APB SETUP/ACCESS
//   sequencing, PREADY wait with optional timeout and per-requester response
//   routing. Exactly one transfer is in flight at a time.
//
// Parameters:
//   NUM_REQ     number of requesters, 1..8
//   NUM_SLAVES  populated PSEL lines, 1..16; higher PSEL bits are tied 0
//   SEL_LSB     PADDR bit where the 4-bit slave index field starts
//   TIMEOUT     max ACCESS cycles waiting for PREADY; 0 disables the timeout
//
// Ports:
//   PCLK     in   APB clock, all state changes on its rising edge
//   PRESETn  in   asynchronous active-low reset
//   bus      master modport of apb_master_arbiter_if (requester handshake,
//            response routing and the APB master signals)
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_SLAVES = 16,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 256
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_master_arbiter_if.master bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_DONE   = 3'd3,
        S_DERR   = 3'd4,
        S_TOUT   = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           r_state, w_state_next;
    logic [PTR_W-1:0] r_ptr,   w_ptr_next;
    logic [PTR_W-1:0] r_owner, w_owner_next;
    logic [31:0]      r_addr,  w_addr_next;
    logic [31:0]      r_wdata, w_wdata_next;
    logic             r_write, w_write_next;
    logic [3:0]       r_idx,   w_idx_next;
    logic [CNT_W-1:0] r_cnt,   w_cnt_next;
    logic [31:0]      r_rdata, w_rdata_next;

    // -----------------------------------------------------------------------
    // Round-robin search
    // The request vector is rotated so that the pointer position lands on
    // bit 0; the first set bit of the rotated vector is the offset of the
    // winner from the pointer.
    // -----------------------------------------------------------------------
    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic                 w_found;
    logic [PTR_W-1:0]     w_off;
    logic [PTR_W:0]       w_sum;
    logic [PTR_W-1:0]     w_win;
    logic [PTR_W-1:0]     w_win_inc;

    assign w_req_dbl = {bus.req_valid, bus.req_valid};
    assign w_req_rot = NUM_REQ'(w_req_dbl >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found = 1'b1;
                w_off   = PTR_W'(k);
            end
        end
    end

    // pointer + offset, wrapped back into 0..NUM_REQ-1
    always_comb begin
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= NUM_REQ_W) begin
            w_win = PTR_W'(w_sum - NUM_REQ_W);
        end else begin
            w_win = w_sum[PTR_W-1:0];
        end
    end

    assign w_win_inc = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    // -----------------------------------------------------------------------
    // Winner payload mux and address decode
    // -----------------------------------------------------------------------
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_write;
    logic [3:0]  w_sel_idx;
    logic        w_idx_ok;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_sel_addr  = bus.req_addr[32*i +: 32];
                w_sel_wdata = bus.req_wdata[32*i +: 32];
                w_sel_write = bus.req_write[i];
            end
        end
    end

    assign w_sel_idx = w_sel_addr[SEL_LSB+3:SEL_LSB];
    assign w_idx_ok  = ({1'b0, w_sel_idx} < 5'(NUM_SLAVES));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_owner <= w_owner_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_write <= w_write_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_rdata <= w_rdata_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_owner_next = r_owner;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_write_next = r_write;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_rdata_next = r_rdata;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_owner_next = w_win;
                    w_ptr_next   = w_win_inc;
                    w_addr_next  = w_sel_addr;
                    w_wdata_next = w_sel_wdata;
                    w_write_next = w_sel_write;
                    w_idx_next   = w_sel_idx;
                    if (w_idx_ok) begin
                        w_cnt_next   = '0;
                        w_state_next = S_SETUP;
                    end else begin
                        // unpopulated slave: answer with an error, no bus cycle
                        w_state_next = S_DERR;
                    end
                end
            end

            S_SETUP: begin
                w_state_next = S_ACCESS;
            end

            S_ACCESS: begin
                w_cnt_next = r_cnt + 1'b1;
                if (bus.PREADY) begin
                    // writes return zero read data
                    w_rdata_next = r_write ? 32'h0 : bus.PRDATA;
                    w_state_next = S_DONE;
                end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                    w_state_next = S_TOUT;
                end
            end

            S_DONE, S_DERR, S_TOUT: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs, all decoded from registered state so reset clears them at once
    // -----------------------------------------------------------------------
    logic w_bus_sel;
    logic w_rsp;

    assign w_bus_sel = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign w_rsp     = (r_state == S_DONE) || (r_state == S_DERR) || (r_state == S_TOUT);

    assign bus.PADDR     = r_addr;
    assign bus.PWDATA    = r_wdata;
    assign bus.PWRITE    = r_write;
    assign bus.PENABLE   = (r_state == S_ACCESS);
    assign bus.rsp_err   = (r_state == S_DERR) || (r_state == S_TOUT);
    assign bus.rsp_rdata = (r_state == S_DONE) ? r_rdata : 32'h0;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_psel
            if (gi < NUM_SLAVES) begin : g_pop
                assign bus.PSEL[gi] = w_bus_sel && (r_idx == 4'(gi));
            end else begin : g_tie
                assign bus.PSEL[gi] = 1'b0;
            end
        end

        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            // the grant is combinational from req_valid, so it is also gated
            // by reset to keep every output low while PRESETn is asserted
            assign bus.req_ready[gi] = PRESETn && (r_state == S_IDLE) && w_found
                                       && (w_win == PTR_W'(gi));
            assign bus.rsp_valid[gi] = w_rsp && (r_owner == PTR_W'(gi));
        end
    endgenerate

endmodule
